// File: rtl/pe_sched_pkg.sv
// Shared definitions for the shared-PE round-robin scheduler.
// Op encodings and the scheduler state type.
package pe_sched_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
// Picks the first set request searching upward from ptr, with wrap.
module rr_arbiter #(
    parameter int N   = 4,
    parameter int IDW = $clog2(N)
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] ptr,
    output logic [N-1:0]   grant,
    output logic [IDW-1:0] idx,
    output logic           any_req
);

    // Rotating priority search starting at ptr
    always_comb begin
        logic           found;
        int             pos;
        logic [IDW-1:0] j;
        grant = '0;
        idx   = '0;
        found = 1'b0;
        pos   = 0;
        j     = '0;
        for (int k = 0; k < N; k++) begin
            pos = int'(ptr) + k;
            if (pos >= N) begin
                pos = pos - N;
            end
            j = IDW'(pos);
            if (!found && req[j]) begin
                found    = 1'b1;
                grant[j] = 1'b1;
                idx      = j;
            end
        end
    end

    assign any_req = |req;

endmodule

// File: rtl/pe_rr_scheduler.sv
// Shares one integer PE among NUM_REQ requesters.
// One op at a time: arbitrate, execute, then hold the response.
module pe_rr_scheduler
    import pe_sched_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 32,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [2*NUM_REQ-1:0]      req_op,
    input  logic [DATA_W*NUM_REQ-1:0] req_inp1,
    input  logic [DATA_W*NUM_REQ-1:0] req_inp2,
    output logic [1:0]                pe_op,
    output logic [DATA_W-1:0]         pe_inp1,
    output logic [DATA_W-1:0]         pe_inp2,
    input  logic [DATA_W-1:0]         pe_out1,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [ID_W-1:0]           rsp_id,
    output logic [DATA_W-1:0]         rsp_data
);

    state_t            state;
    logic [ID_W-1:0]   rr_ptr;
    logic [ID_W-1:0]   grant;
    logic [NUM_REQ-1:0] arb_grant;
    logic [ID_W-1:0]   arb_idx;
    logic              any_req;

    logic [1:0]        op_arr   [NUM_REQ];
    logic [DATA_W-1:0] inp1_arr [NUM_REQ];
    logic [DATA_W-1:0] inp2_arr [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign op_arr[i]   = req_op[2*i +: 2];
        assign inp1_arr[i] = req_inp1[DATA_W*i +: DATA_W];
        assign inp2_arr[i] = req_inp2[DATA_W*i +: DATA_W];
    end

    rr_arbiter #(
        .N   (NUM_REQ),
        .IDW (ID_W)
    ) u_arb (
        .req     (req_valid),
        .ptr     (rr_ptr),
        .grant   (arb_grant),
        .idx     (arb_idx),
        .any_req (any_req)
    );

    // Accept only while idle; the handshake completes in the same cycle
    assign req_ready = (state == IDLE && !rst) ? arb_grant : '0;

    // Scheduler FSM: latch operands, capture result, hold until taken
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            grant     <= '0;
            pe_op     <= '0;
            pe_inp1   <= '0;
            pe_inp2   <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_data  <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (any_req) begin
                        pe_op   <= op_arr[arb_idx];
                        pe_inp1 <= inp1_arr[arb_idx];
                        pe_inp2 <= inp2_arr[arb_idx];
                        grant   <= arb_idx;
                        state   <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_data  <= pe_out1;
                    rsp_id    <= grant;
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        rr_ptr    <= (grant == ID_W'(NUM_REQ - 1))
                                   ? '0 : grant + 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pe_rr_scheduler.sv
// Randomized bench for pe_rr_scheduler.
// Transaction-level round-robin model plus a behavioural PE.
module tb_pe_rr_scheduler;

    localparam int N  = 4;
    localparam int W  = 32;
    localparam int IW = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_ready;
    logic [2*N-1:0]    req_op;
    logic [W*N-1:0]    req_inp1;
    logic [W*N-1:0]    req_inp2;
    logic [1:0]        pe_op;
    logic [W-1:0]      pe_inp1;
    logic [W-1:0]      pe_inp2;
    logic [W-1:0]      pe_out1;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [IW-1:0]     rsp_id;
    logic [W-1:0]      rsp_data;

    pe_rr_scheduler #(
        .NUM_REQ (N),
        .DATA_W  (W),
        .ID_W    (IW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_inp1  (req_inp1),
        .req_inp2  (req_inp2),
        .pe_op     (pe_op),
        .pe_inp1   (pe_inp1),
        .pe_inp2   (pe_inp2),
        .pe_out1   (pe_out1),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] alu(
        input logic [1:0] op,
        input logic [W-1:0] a,
        input logic [W-1:0] b
    );
        case (op)
            2'b01:   return a - b;
            2'b10:   return a * b;
            default: return a + b;
        endcase
    endfunction

    // Behavioural PE on the registered operands
    assign pe_out1 = alu(pe_op, pe_inp1, pe_inp2);

    int n_vec = 0;
    int n_bad = 0;

    // Requester side
    logic       v      [N];
    logic [1:0] o      [N];
    logic [W-1:0] a    [N];
    logic [W-1:0] b    [N];
    bit         refill [N];
    int         arrive_pct;
    int         rmode;

    // Reference model
    int         ptr;
    bit         busy;
    int         cyc;
    int         exp_id;
    logic [W-1:0] exp_data;
    logic [1:0]   last_op;
    logic [W-1:0] last_a;
    logic [W-1:0] last_b;

    task automatic chk(input string tag,
                       input logic [W-1:0] got,
                       input logic [W-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    task automatic new_req(input int i);
        v[i] = 1'b1;
        o[i] = 2'($urandom_range(0, 3));
        a[i] = $urandom_range(0, 1) ? $urandom : $urandom_range(0, 255);
        b[i] = $urandom_range(0, 1) ? $urandom : $urandom_range(0, 255);
    endtask

    task automatic set_req(input int i, input logic [1:0] op,
                           input logic [W-1:0] x, input logic [W-1:0] y);
        v[i] = 1'b1;
        o[i] = op;
        a[i] = x;
        b[i] = y;
    endtask

    task automatic step();
        bit           found;
        int           win;
        int           j;
        logic [W-1:0] e;
        logic         rdy;
        for (int i = 0; i < N; i++) begin
            if (!v[i] && arrive_pct > 0 &&
                $urandom_range(0, 99) < arrive_pct) begin
                new_req(i);
            end
            req_valid[i]        = v[i];
            req_op[2*i +: 2]    = o[i];
            req_inp1[W*i +: W]  = a[i];
            req_inp2[W*i +: W]  = b[i];
        end
        rsp_ready = (rmode == 2) ? 1'($urandom_range(0, 1))
                                 : (rmode == 1);
        #1;
        found = 1'b0;
        win   = 0;
        if (!busy) begin
            for (int k = 0; k < N; k++) begin
                j = (ptr + k) % N;
                if (!found && v[j]) begin
                    found = 1'b1;
                    win   = j;
                end
            end
        end
        e = '0;
        if (found) e[win] = 1'b1;
        chk("req_ready", W'(req_ready), e);
        chk("pe_op", W'(pe_op), W'(last_op));
        chk("pe_inp1", pe_inp1, last_a);
        chk("pe_inp2", pe_inp2, last_b);
        chk("rsp_valid", W'(rsp_valid), W'(busy && cyc >= 1));
        if (busy && cyc >= 1) begin
            chk("rsp_id", W'(rsp_id), W'(exp_id));
            chk("rsp_data", rsp_data, exp_data);
        end
        rdy = rsp_ready;
        @(posedge clk);
        if (found) begin
            busy     = 1'b1;
            cyc      = 0;
            exp_id   = win;
            exp_data = alu(o[win], a[win], b[win]);
            last_op  = o[win];
            last_a   = a[win];
            last_b   = b[win];
            if (refill[win]) new_req(win);
            else v[win] = 1'b0;
        end else if (busy) begin
            if (cyc >= 1 && rdy) begin
                busy = 1'b0;
                ptr  = (exp_id + 1) % N;
            end else if (cyc < 2) begin
                cyc++;
            end
        end
        @(negedge clk);
    endtask

    // Asynchronous reset applied in the low phase, checked before any edge
    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("rst_req_ready", W'(req_ready), '0);
        chk("rst_pe_op", W'(pe_op), '0);
        chk("rst_pe_inp1", pe_inp1, '0);
        chk("rst_pe_inp2", pe_inp2, '0);
        chk("rst_rsp_valid", W'(rsp_valid), '0);
        chk("rst_rsp_id", W'(rsp_id), '0);
        chk("rst_rsp_data", rsp_data, '0);
        busy    = 1'b0;
        cyc     = 0;
        ptr     = 0;
        last_op = '0;
        last_a  = '0;
        last_b  = '0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_op    = '0;
        req_inp1  = '0;
        req_inp2  = '0;
        rsp_ready = 1'b0;
        for (int i = 0; i < N; i++) begin
            v[i] = 1'b0; o[i] = '0; a[i] = '0; b[i] = '0;
            refill[i] = 1'b0;
        end
        arrive_pct = 0;
        rmode      = 1;
        @(negedge clk);
        do_reset();

        // single add
        set_req(0, 2'b00, 32'd5, 32'd7);
        repeat (4) step();

        // all four subtract, fresh pointer
        do_reset();
        for (int i = 0; i < N; i++) begin
            set_req(i, 2'b01, 32'(10 + i), 32'(i));
        end
        repeat (14) step();

        // wrapping multiply and op 11
        set_req(2, 2'b10, 32'hFFFF_FFFF, 32'd2);
        repeat (4) step();
        set_req(1, 2'b11, 32'd3, 32'd4);
        repeat (4) step();

        // backpressure with a waiting requester
        rmode = 0;
        set_req(0, 2'b00, 32'd100, 32'd1);
        step();
        set_req(1, 2'b01, 32'd9, 32'd4);
        repeat (7) step();
        rmode = 1;
        repeat (6) step();

        // continuous req0, req3 arrives mid-stream
        refill[0] = 1'b1;
        new_req(0);
        repeat (4) step();
        new_req(3);
        repeat (12) step();
        refill[0] = 1'b0;
        repeat (8) step();

        // reset during EXEC discards the op and the pointer
        do_reset();
        set_req(1, 2'b00, 32'd1, 32'd1);
        repeat (4) step();
        set_req(2, 2'b10, 32'd6, 32'd7);
        step();
        do_reset();
        set_req(1, 2'b00, 32'd20, 32'd22);
        set_req(3, 2'b01, 32'd20, 32'd22);
        repeat (8) step();

        // random traffic with random backpressure
        arrive_pct = 30;
        rmode      = 2;
        repeat (3000) step();

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_bad);
        $finish;
    end

endmodule
